// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and the
// width of the big-endian length header that precedes the image.
// Optional feature macro: CHECKSUM_EN adds the CHK state.
package boot_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
`ifdef CHECKSUM_EN
    CHK    = 3'd4,
`endif
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/boot_loader_byte_counter.sv
// Byte counter for the load session. One bit wider than the address so a
// full-memory image (LEN = 2^ADDR_W) reaches its terminal count without
// wrapping. 'last' flags that the byte about to be accepted is byte LEN-1.
module loader_byte_counter
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int CMP_W = (ADDR_W + 1 > LEN_W) ? ADDR_W + 1 : LEN_W;

  logic [ADDR_W:0]  count;
  logic [CMP_W-1:0] count_ext;
  logic [CMP_W-1:0] len_ext;

  assign count_ext = CMP_W'(count);
  assign len_ext   = CMP_W'(len);
  assign last      = (count_ext + CMP_W'(1)) == len_ext;
  assign addr      = count[ADDR_W-1:0];

  // count accepted data bytes; cleared at the start of every session
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into
// instruction memory from address 0 while holding the CPU in reset.
// Releases the CPU (done=1, cpu_hold=0) only after a complete, valid load.
// Optional feature macro: CHECKSUM_EN -- a trailing XOR byte must match.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LEN_HI | expecting length MSB
// LEN_LO | expecting length LSB, then validating LEN
// DATA   | writing image bytes to memory
// CHK    | expecting checksum byte (CHECKSUM_EN only)
// DONE   | load complete, CPU released
// ERR    | load aborted, CPU held
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(2 ** ADDR_W);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_next;
  logic              len_bad;
  logic              accept;
  logic              session_go;
  logic              cnt_inc;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;
`ifdef CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // handshake, session start and length validation decode
  always_comb begin
    accept     = s_valid & s_ready;
    session_go = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    cnt_inc    = accept & (state == DATA);
    len_next   = {len[LEN_W-1:8], s_data};
    len_bad    = (len_next == '0) | ({1'b0, len_next} > MAX_LEN) | (len_next[1:0] != 2'b00);
  end

  loader_byte_counter #(.ADDR_W(ADDR_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (session_go),
    .inc   (cnt_inc),
    .len   (len),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  // session FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len       <= '0;
      s_ready   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (session_go) begin
        state    <= LEN_HI;
        s_ready  <= 1'b1;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
`ifdef CHECKSUM_EN
        csum     <= '0;
`endif
      end else begin
        case (state)
          LEN_HI: if (accept) begin
            len[LEN_W-1:8] <= s_data;
            state          <= LEN_LO;
          end
          LEN_LO: if (accept) begin
            len[7:0] <= s_data;
            if (len_bad) begin
              state   <= ERR;
              s_ready <= 1'b0;
              err     <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt_addr;
            mem_wdata <= s_data;
`ifdef CHECKSUM_EN
            csum      <= csum ^ s_data;
            if (cnt_last)
              state <= CHK;
`else
            if (cnt_last) begin
              state   <= DONE;
              s_ready <= 1'b0;
            end
`endif
          end
`ifdef CHECKSUM_EN
          CHK: if (accept) begin
            s_ready <= 1'b0;
            if (s_data == csum) begin
              state <= DONE;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
`endif
          // release the CPU one cycle after entry, i.e. after the last write
          DONE: begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader. Expected memory writes are queued as
// stimulus bytes are sent and popped by a write monitor on the falling edge.
module tb_boot_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W+7:0] mon_e;
  logic [7:0]        pay[$];

  boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // write monitor: every mem_we pulse must match the next queued write
  always @(negedge clk) begin
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%02h required none", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_e) begin
          failures++;
          $display("FAIL write got addr=%0d data=%02h required addr=%0d data=%02h",
                   mem_addr, mem_wdata, mon_e[ADDR_W+7:8], mon_e[7:0]);
        end
      end
    end
  end

  // all tasks enter and leave on a falling edge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (s_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout byte=%02h got s_ready=0 required 1", b);
    end
    @(negedge clk);
  endtask

  // full successful session using the bytes in pay, gap idle cycles between bytes
  task automatic session(input logic [15:0] len, input int gap);
    logic [7:0] x = 8'h00;
    pulse_start();
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int k = 0; k < pay.size(); k++) begin
      exp_q.push_back({ADDR_W'(k), pay[k]});
      x ^= pay[k];
      send_byte(pay[k]);
      if (k != pay.size() - 1) begin
        for (int g = 0; g < gap; g++) begin
          s_valid = 1'b0;
          checks++;
          if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL gap_ready got %b required 1", s_ready);
          end
          @(negedge clk);
        end
      end
    end
`ifdef CHECKSUM_EN
    send_byte(x);
`endif
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_early got %b required 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_state got done=%b hold=%b err=%b rdy=%b required 1 0 0 0",
               done, cpu_hold, err, s_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL writes_missing got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_hold, s_ready, mem_we, done, err} !== 5'b10000 || mem_addr !== '0 || mem_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_values got hold=%b rdy=%b we=%b done=%b err=%b addr=%0d data=%02h required 1 0 0 0 0 0 00",
               cpu_hold, s_ready, mem_we, done, err, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    pay = '{8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h28, 8'h00, 8'h00};
    session(16'h0008, 0);
  endtask

  task automatic test_bad_len();
    logic [15:0] lens[4] = '{16'h0006, 16'h0000, 16'h0005, 16'h0104};
    for (int i = 0; i < 4; i++) begin
      pulse_start();
      send_byte(lens[i][15:8]);
      send_byte(lens[i][7:0]);
      s_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || cpu_hold !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL bad_len len=%04h got err=%b hold=%b rdy=%b done=%b required 1 1 0 0",
                 lens[i], err, cpu_hold, s_ready, done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 1'b1 || cpu_hold !== 1'b1) begin
        failures++;
        $display("FAIL bad_len_hold len=%04h got err=%b hold=%b required 1 1", lens[i], err, cpu_hold);
      end
    end
  endtask

  task automatic test_gaps();
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom_range(0, 255)));
    session(16'h0004, 3);
  endtask

  task automatic test_mid_reset();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h08);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({ADDR_W'(k), 8'(8'hA0 + k)});
      send_byte(8'(8'hA0 + k));
    end
    s_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cpu_hold, s_ready, mem_we, done, err} !== 5'b10000 || mem_addr !== '0 || mem_wdata !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset got hold=%b rdy=%b we=%b done=%b err=%b addr=%0d data=%02h required 1 0 0 0 0 0 00",
               cpu_hold, s_ready, mem_we, done, err, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    session(16'h0004, 0);
  endtask

  task automatic test_full();
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'(i) ^ 8'h5A);
    session(16'h0100, 0);
  endtask

  task automatic test_ignore_valid();
    s_valid = 1'b1;
    s_data  = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_ready !== 1'b0 || done !== 1'b1) begin
        failures++;
        $display("FAIL ignore_valid got rdy=%b done=%b required 0 1", s_ready, done);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] chk[2] = '{8'h04, 8'h05};
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h04);
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({ADDR_W'(k), 8'(k + 1)});
        send_byte(8'(k + 1));
      end
      send_byte(chk[r]);
      s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (r == 0 && (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0)) begin
        failures++;
        $display("FAIL chk_good got done=%b err=%b hold=%b required 1 0 0", done, err, cpu_hold);
      end else if (r == 1 && (done !== 1'b0 || err !== 1'b1 || cpu_hold !== 1'b1)) begin
        failures++;
        $display("FAIL chk_bad got done=%b err=%b hold=%b required 0 1 1", done, err, cpu_hold);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_valid();
    test_bad_len();
    test_gaps();
    test_mid_reset();
    test_full();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
